// File: rtl/bcp_pkg.sv
// Shared types for the BCP clause walker: literals, node pointers,
// clause nodes and the walker FSM state.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 16
`endif

package bcp_pkg;
    localparam int DEPTH       = 16;
    localparam int CLAUSE_W    = 3;
    localparam int LIT_IDX_MAX = `LIT_IDX_MAX;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic signed [LIT_W-1:0] lit_t;

    localparam ptr_t NULL_PTR = '0;

    typedef struct packed {
        lit_t [CLAUSE_W-1:0] lit;
        ptr_t                next;
    } node_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_EMIT,
        S_DONE
    } bcp_state_e;
endpackage

// File: rtl/bcp_walker_clause_eval.sv
// Combinational clause classifier: satisfied, conflicting or unit
// under the current partial variable assignment.
module clause_eval
    import bcp_pkg::*;
(
    input  lit_t [CLAUSE_W-1:0]     lit,
    input  logic [LIT_IDX_MAX-1:0]  var_assigned,
    input  logic [LIT_IDX_MAX-1:0]  var_value,
    output logic                    sat,
    output logic                    conflict,
    output logic                    unit,
    output lit_t                    unit_lit
);
    logic [CLAUSE_W-1:0] s_true;
    logic [CLAUSE_W-1:0] s_unas;

    // Shifting by |lit| keeps out-of-range indices reading as unassigned.
    for (genvar i = 0; i < CLAUSE_W; i++) begin : g_slot
        logic [LIT_W-1:0]       mag;
        logic [LIT_IDX_MAX-1:0] a_sh;
        logic [LIT_IDX_MAX-1:0] v_sh;
        logic                   nz;

        assign mag  = lit[i][LIT_W-1] ? LIT_W'(-lit[i]) : LIT_W'(lit[i]);
        assign a_sh = var_assigned >> mag;
        assign v_sh = var_value >> mag;
        assign nz   = (lit[i] != '0);
        assign s_unas[i] = nz && !a_sh[0];
        assign s_true[i] = nz && a_sh[0] && (v_sh[0] == !lit[i][LIT_W-1]);
    end

    always_comb begin
        unit_lit = '0;
        for (int i = 0; i < CLAUSE_W; i++) begin
            if (s_unas[i]) unit_lit = lit[i];
        end
        sat      = |s_true;
        unit     = !sat && ($countones(s_unas) == 1);
        conflict = !sat && (s_unas == '0);
    end
endmodule

// File: rtl/bcp_walker.sv
// Walks a clause linked list one node per cycle, emitting unit
// implications and stopping on conflict, list end or walk overrun.
module bcp_walker
    import bcp_pkg::*;
#(
    parameter int MAX_WALK = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  ptr_t                   clq2bcp_init_ptr,
    input  logic                   clq2bcp_init_ptr_valid,
    output ptr_t                   bcp2clq_cnf_idx,
    input  node_t                  clq2bcp_node_out,
    input  logic [LIT_IDX_MAX-1:0] var_assigned,
    input  logic [LIT_IDX_MAX-1:0] var_value,
    output logic                   bcp_ready,
    output lit_t                   bcp2ucq_imp_lit,
    output logic                   bcp2ucq_imp_valid,
    input  logic                   ucq2bcp_imp_ready,
    output logic                   bcp_conflict,
    output logic                   bcp_overrun,
    output logic                   bcp_done
);
    localparam int CNT_W = $clog2(MAX_WALK) + 1;
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(MAX_WALK - 1);

    bcp_state_e       state;
    ptr_t             cur_ptr;
    logic [CNT_W-1:0] walk_cnt;

    logic ev_sat;
    logic ev_conflict;
    logic ev_unit;
    lit_t ev_lit;
    logic adv;
    ptr_t adv_ptr;

    clause_eval u_eval (
        .lit          (clq2bcp_node_out.lit),
        .var_assigned (var_assigned),
        .var_value    (var_value),
        .sat          (ev_sat),
        .conflict     (ev_conflict),
        .unit         (ev_unit),
        .unit_lit     (ev_lit)
    );

    assign bcp2clq_cnf_idx = (state == S_WALK) ? cur_ptr : NULL_PTR;

    // In EMIT the successor pointer was already captured into cur_ptr.
    assign adv = ((state == S_WALK) && (ev_sat || !(ev_conflict || ev_unit)))
              || ((state == S_EMIT) && ucq2bcp_imp_ready);
    assign adv_ptr = (state == S_EMIT) ? cur_ptr : clq2bcp_node_out.next;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state             <= S_IDLE;
            cur_ptr           <= NULL_PTR;
            walk_cnt          <= '0;
            bcp_ready         <= 1'b1;
            bcp2ucq_imp_lit   <= '0;
            bcp2ucq_imp_valid <= 1'b0;
            bcp_conflict      <= 1'b0;
            bcp_overrun       <= 1'b0;
            bcp_done          <= 1'b0;
        end else begin
            bcp_conflict <= 1'b0;
            bcp_overrun  <= 1'b0;
            bcp_done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (clq2bcp_init_ptr_valid) begin
                        cur_ptr   <= clq2bcp_init_ptr;
                        walk_cnt  <= '0;
                        bcp_ready <= 1'b0;
                        if (clq2bcp_init_ptr == NULL_PTR) begin
                            state    <= S_DONE;
                            bcp_done <= 1'b1;
                        end else begin
                            state <= S_WALK;
                        end
                    end
                end
                S_WALK: begin
                    if (ev_conflict) begin
                        bcp_conflict <= 1'b1;
                        bcp_done     <= 1'b1;
                        state        <= S_DONE;
                    end else if (ev_unit) begin
                        bcp2ucq_imp_lit   <= ev_lit;
                        bcp2ucq_imp_valid <= 1'b1;
                        cur_ptr           <= clq2bcp_node_out.next;
                        state             <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (ucq2bcp_imp_ready) bcp2ucq_imp_valid <= 1'b0;
                end
                S_DONE: begin
                    bcp_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
            if (adv) begin
                walk_cnt <= walk_cnt + CNT_W'(1);
                cur_ptr  <= adv_ptr;
                if (adv_ptr == NULL_PTR || walk_cnt == WALK_LAST) begin
                    bcp_overrun <= (adv_ptr != NULL_PTR);
                    bcp_done    <= 1'b1;
                    state       <= S_DONE;
                end else begin
                    state <= S_WALK;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcp_walker.sv
// Scoreboard bench for bcp_walker: a list-walking reference model
// predicts visits, implications and walk outcome.
module tb_bcp_walker;
    import bcp_pkg::*;

    localparam int MAX_WALK = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    ptr_t                   clq2bcp_init_ptr = '0;
    logic                   clq2bcp_init_ptr_valid = 1'b0;
    ptr_t                   bcp2clq_cnf_idx;
    node_t                  clq2bcp_node_out;
    logic [LIT_IDX_MAX-1:0] va = '0;
    logic [LIT_IDX_MAX-1:0] vv = '0;
    logic                   bcp_ready;
    lit_t                   bcp2ucq_imp_lit;
    logic                   bcp2ucq_imp_valid;
    logic                   ucq2bcp_imp_ready = 1'b0;
    logic                   bcp_conflict;
    logic                   bcp_overrun;
    logic                   bcp_done;

    node_t mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_idx [$];
    int exp_lit [$];
    int exp_end [$];
    int idx_cyc [$];

    bcp_walker #(.MAX_WALK(MAX_WALK)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .clq2bcp_init_ptr       (clq2bcp_init_ptr),
        .clq2bcp_init_ptr_valid (clq2bcp_init_ptr_valid),
        .bcp2clq_cnf_idx        (bcp2clq_cnf_idx),
        .clq2bcp_node_out       (clq2bcp_node_out),
        .var_assigned           (va),
        .var_value              (vv),
        .bcp_ready              (bcp_ready),
        .bcp2ucq_imp_lit        (bcp2ucq_imp_lit),
        .bcp2ucq_imp_valid      (bcp2ucq_imp_valid),
        .ucq2bcp_imp_ready      (ucq2bcp_imp_ready),
        .bcp_conflict           (bcp_conflict),
        .bcp_overrun            (bcp_overrun),
        .bcp_done               (bcp_done)
    );

    assign clq2bcp_node_out = mem[bcp2clq_cnf_idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic node_t mk(int a, int b, int c, int nx);
        node_t n;
        n.lit[0] = lit_t'(a);
        n.lit[1] = lit_t'(b);
        n.lit[2] = lit_t'(c);
        n.next   = ptr_t'(nx);
        return n;
    endfunction

    // Reference: follow the list, classify each clause from its literals.
    // End codes: 0 list end, 1 conflict, 2 overrun.
    task automatic model_walk(int head);
        int p;
        int k;
        p = head;
        k = 0;
        if (head == 0) begin
            exp_end.push_back(0);
            return;
        end
        forever begin
            int n_true;
            int n_unas;
            int u_lit;
            n_true = 0;
            n_unas = 0;
            u_lit = 0;
            exp_idx.push_back(p);
            k++;
            for (int s = 0; s < CLAUSE_W; s++) begin
                int l;
                int v;
                l = int'($signed(mem[p].lit[s]));
                if (l != 0) begin
                    v = (l < 0) ? -l : l;
                    if (!va[v]) begin
                        n_unas++;
                        u_lit = l;
                    end else if (vv[v] == (l > 0)) begin
                        n_true++;
                    end
                end
            end
            if (n_true == 0 && n_unas == 0) begin
                exp_end.push_back(1);
                return;
            end
            if (n_true == 0 && n_unas == 1) exp_lit.push_back(u_lit);
            if (int'(mem[p].next) == 0) begin
                exp_end.push_back(0);
                return;
            end
            if (k == MAX_WALK) begin
                exp_end.push_back(2);
                return;
            end
            p = int'(mem[p].next);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents something.
    int   e;
    logic hold_prev = 1'b0;
    int   prev_lit = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (bcp2clq_cnf_idx != '0) begin
                if (exp_idx.size() == 0) begin
                    chk("idx_extra", int'(bcp2clq_cnf_idx), -1);
                end else begin
                    e = exp_idx.pop_front();
                    chk("walk_idx", int'(bcp2clq_cnf_idx), e);
                    idx_cyc.push_back(cyc);
                end
            end
            if (hold_prev) begin
                chk("valid_held", int'(bcp2ucq_imp_valid), 1);
                chk("lit_stable", int'($signed(bcp2ucq_imp_lit)), prev_lit);
            end
            if (bcp2ucq_imp_valid && ucq2bcp_imp_ready) begin
                if (exp_lit.size() == 0) begin
                    chk("lit_extra", int'($signed(bcp2ucq_imp_lit)), 0);
                end else begin
                    e = exp_lit.pop_front();
                    chk("imp_lit", int'($signed(bcp2ucq_imp_lit)), e);
                end
            end
            hold_prev = bcp2ucq_imp_valid && !ucq2bcp_imp_ready;
            prev_lit  = int'($signed(bcp2ucq_imp_lit));
            if (bcp_done) begin
                e = (exp_end.size() == 0) ? -1 : exp_end.pop_front();
                chk("end_code", bcp_overrun ? 2 : (bcp_conflict ? 1 : 0), e);
                chk("both_flags", int'(bcp_overrun && bcp_conflict), 0);
                chk("idx_left", exp_idx.size(), 0);
                chk("lit_left", exp_lit.size(), 0);
                chk("ready_in_done", int'(bcp_ready), 0);
                done_cnt++;
            end else if (bcp_conflict || bcp_overrun) begin
                chk("flag_wo_done", int'({bcp_conflict, bcp_overrun}), 0);
            end
        end
    end

    task automatic flush();
        exp_idx.delete();
        exp_lit.delete();
        exp_end.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        flush();
    endtask

    task automatic run_walk(int head, int hold);
        int d0;
        int n;
        int h;
        h = hold;
        model_walk(head);
        n = 0;
        while (!bcp_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        d0 = done_cnt;
        clq2bcp_init_ptr = ptr_t'(head);
        clq2bcp_init_ptr_valid = 1'b1;
        @(posedge clk);
        #1;
        clq2bcp_init_ptr_valid = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            if (bcp2ucq_imp_valid && h > 0) begin
                ucq2bcp_imp_ready = 1'b0;
                h--;
            end else begin
                ucq2bcp_imp_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt == d0) begin
            chk("walk_timeout", done_cnt - d0, 1);
            do_reset();
        end
        flush();
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(bcp_ready), 1);
        chk("rst_idx", int'(bcp2clq_cnf_idx), 0);
        chk("rst_valid", int'(bcp2ucq_imp_valid), 0);
        chk("rst_lit", int'(bcp2ucq_imp_lit), 0);
        chk("rst_flags", int'({bcp_conflict, bcp_overrun, bcp_done}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Empty list
        run_walk(0, 0);

        // Single implication with ready held low
        mem[3] = mk(1, -2, 4, 0);
        va = 16'b0000_0000_0000_0110;
        vv = 16'b0000_0000_0000_0100;
        run_walk(3, 3);

        // Conflict aborts before node 5
        mem[2] = mk(1, 2, 0, 5);
        mem[5] = mk(7, 0, 0, 0);
        va = 16'b0000_0000_0000_0110;
        vv = 16'b0000_0000_0000_0000;
        run_walk(2, 0);

        // Satisfied chain 1 -> 2 -> 3 on consecutive cycles
        mem[1] = mk(1, 0, 0, 2);
        mem[2] = mk(0, -2, 0, 3);
        mem[3] = mk(5, 3, 0, 0);
        va = 16'b0000_0000_0000_1110;
        vv = 16'b0000_0000_0000_1010;
        idx_cyc.delete();
        run_walk(1, 0);
        chk("chain_visits", idx_cyc.size(), 3);
        if (idx_cyc.size() == 3) chk("chain_span", idx_cyc[2] - idx_cyc[0], 2);

        // Self-loop overrun
        mem[4] = mk(1, 0, 0, 4);
        va = 16'b0000_0000_0000_0010;
        vv = 16'b0000_0000_0000_0010;
        idx_cyc.delete();
        run_walk(4, 0);
        chk("overrun_visits", idx_cyc.size(), MAX_WALK);

        // Reset during a pending implication
        mem[3] = mk(1, -2, 4, 0);
        va = 16'b0000_0000_0000_0110;
        vv = 16'b0000_0000_0000_0100;
        model_walk(3);
        ucq2bcp_imp_ready = 1'b0;
        clq2bcp_init_ptr = ptr_t'(3);
        clq2bcp_init_ptr_valid = 1'b1;
        @(posedge clk);
        #1;
        clq2bcp_init_ptr_valid = 1'b0;
        n = 0;
        while (!bcp2ucq_imp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("emit_reached", int'(bcp2ucq_imp_valid), 1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", int'(bcp2ucq_imp_valid), 0);
        chk("mid_rst_ready", int'(bcp_ready), 1);
        chk("mid_rst_idx", int'(bcp2clq_cnf_idx), 0);
        chk("mid_rst_done", int'(bcp_done), 0);
        flush();
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Randomized lists and assignments
        for (int t = 0; t < 40; t++) begin
            for (int p = 1; p < DEPTH; p++) begin
                int l [CLAUSE_W];
                for (int s = 0; s < CLAUSE_W; s++) begin
                    if ($urandom_range(0, 9) < 3) l[s] = 0;
                    else begin
                        l[s] = $urandom_range(1, 15);
                        if ($urandom_range(0, 1) == 1) l[s] = -l[s];
                    end
                end
                mem[p] = mk(l[0], l[1], l[2],
                            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15));
            end
            va = LIT_IDX_MAX'($urandom);
            vv = LIT_IDX_MAX'($urandom);
            run_walk($urandom_range(0, 15), $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcp_walker.md
Name: bcp_walker

Overview:
- Downstream consumer of cla_queue and the core of the BCP engine.
- Accepts a list-head pointer for a newly assigned literal, then walks the clause linked list one node per cycle through the queue's indexed read port.
- Evaluates each clause against the current variable assignment.
- Emits each implied unit literal to the unit-clause queue, or flags a conflict and aborts the walk.

Parameters:
- DEPTH, 16, clause-node buffer depth; must match cla_queue; ptr_t is $clog2(DEPTH) bits.
- CLAUSE_W, 3, literal slots per node.
- MAX_WALK, 16, node-visit limit per walk (cycle guard).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-high despite the name (codebase convention).
- clq2bcp_init_ptr  in  ptr_t  list-head pointer from cla_queue.
- clq2bcp_init_ptr_valid  in  1  head pointer valid; consumed only in IDLE.
- bcp2clq_cnf_idx  out  ptr_t  node read index; combinational read.
- clq2bcp_node_out  in  node_t  node at bcp2clq_cnf_idx, same cycle.
- var_assigned  in  LIT_IDX_MAX  per-variable assigned flag.
- var_value  in  LIT_IDX_MAX  per-variable value; 1 means the positive literal is true.
- bcp_ready  out  1  high only in IDLE.
- bcp2ucq_imp_lit  out  lit_t  implied literal.
- bcp2ucq_imp_valid  out  1  implied literal valid.
- ucq2bcp_imp_ready  in  1  unit-clause queue accepts.
- bcp_conflict  out  1  one-cycle pulse on conflict.
- bcp_overrun  out  1  one-cycle pulse when MAX_WALK is exceeded.
- bcp_done  out  1  one-cycle pulse when the walk ends.

Behaviour:
- Literal encoding (lit_t): signed two's-complement, $clog2(LIT_IDX_MAX)+1 bits. Value 0 is an empty slot. Variable index is |lit|. A literal is true iff var_assigned and (var_value XNOR lit>0).
- node_t fields: lit[CLAUSE_W], next (ptr_t). NULL_PTR = 0 and buffer slot 0 is never a clause. A node is last when next == NULL_PTR.
- Reset state:
  - FSM = IDLE, cur_ptr = 0, walk_cnt = 0.
  - All outputs 0, except bcp_ready = 1; bcp2clq_cnf_idx = 0.
- IDLE:
  - bcp_ready = 1.
  - On init_ptr_valid: latch cur_ptr <= init_ptr and clear walk_cnt.
  - Next state is WALK, or DONE if init_ptr == NULL_PTR.
- WALK:
  - bcp2clq_cnf_idx = cur_ptr. The node is evaluated combinationally in the same cycle.
  - Nonzero slots are classified as true, false (assigned, opposite value) or unassigned.
  - Any true slot: clause satisfied, advance.
  - No true slot and exactly one unassigned slot: latch that literal into imp_lit, go to EMIT.
  - No true and no unassigned slot, including an all-empty node: pulse bcp_conflict, go to DONE. The remaining list is not visited.
  - Otherwise: advance.
- Advance:
  - walk_cnt++ and cur_ptr <= next.
  - If next == NULL_PTR: go to DONE.
  - Else if walk_cnt+1 == MAX_WALK: pulse bcp_overrun, go to DONE.
  - Else stay in WALK.
  - Throughput: one node per cycle when there are no implications.
- EMIT:
  - imp_valid = 1 with imp_lit held stable until ucq2bcp_imp_ready.
  - Transfer happens on the cycle where valid and ready are both high. That cycle performs the advance rule; imp_valid drops the next cycle.
  - Valid is never withdrawn before transfer.
- DONE: bcp_done = 1 for exactly one cycle, then IDLE. A new init_ptr_valid is accepted only from the following IDLE cycle.
- Assignment inputs are sampled live each WALK cycle. The upstream stage holds them stable for the duration of a walk.
- init_ptr_valid outside IDLE is ignored.
- Reset asserted mid-walk or mid-EMIT: all state returns to reset values next cycle and any pending implication is dropped.
- walk_cnt is $clog2(MAX_WALK)+1 bits and never wraps.

Decomposition:
- Shared package (bcp_pkg):
  - lit_t, ptr_t, node_t.
  - NULL_PTR, CLAUSE_W.
  - LIT_IDX_MAX (from the existing define).
  - FSM state enum.
- Sub-module clause_eval: combinational. Inputs are node lits and the assignment vectors; outputs are sat, conflict, unit, unit_lit.

Test Plan:
- Empty list: init_ptr=0 -> no cnf_idx walk, bcp_done pulses 2 cycles after valid, no implication.
- Single implication: node@3 {+1,-2,+4}, next=0; var1=0, var2=1, var4 unassigned -> imp_lit=+4 valid; hold ready low 3 cycles -> lit stable; then done.
- Conflict aborts: node@2 {+1,+2,0} next=5, var1=0, var2=0 -> bcp_conflict pulse, idx 5 never driven, done next.
- Satisfied skip chain: nodes 1->2->3 all satisfied -> cnf_idx 1,2,3 on consecutive cycles, no imp_valid, done.
- Overrun: self-loop node@4 next=4 with MAX_WALK=16 -> bcp_overrun after 16 visits, then done.
- Reset mid-EMIT: assert rst_n during imp_valid -> next cycle imp_valid=0, bcp_ready=1, FSM IDLE.
